// File: rtl/core_top.sv
// core_top: out-of-order back end with dispatch, per-FU scheduler slots, 1-cycle ALU/branch units, PRF and in-order ROB.
// Define COMMIT_TRACE_EN to print one trace line per retired instruction.
module core_top #(
   parameter int RS_ENTRIES  = 4,
   parameter int NUM_FUS     = 2,
   parameter int ROB_ENTRIES = 8,
   parameter int NUM_AREGS   = 32,
   parameter int NUM_PREGS   = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           disp_valid,
   input  logic [RS_ENTRIES*NUM_FUS-1:0]  dependency_mask,
   input  logic [2:0]                     disp_opcode,
   input  logic [31:0]                    disp_pc,
   input  logic [$clog2(ROB_ENTRIES)-1:0] disp_rob_idx,
   input  logic [$clog2(NUM_AREGS)-1:0]   disp_dst_areg,
   input  logic [$clog2(NUM_PREGS)-1:0]   disp_dst_preg,
   input  logic [31:0]                    disp_imm,
   input  logic                           disp_instr_valid,
   input  logic                           disp_alu_en,
   input  logic                           disp_br_taken,
   input  logic                           rob_fire_valid,
   input  logic [$clog2(NUM_AREGS)-1:0]   rob_dest_reg,
   input  logic                           rob_wb_en,
   output logic                           disp_ready,
   output logic                           commit_valid,
   output logic [$clog2(NUM_AREGS)-1:0]   commit_areg,
   output logic [31:0]                    commit_value,
   output logic [31:0]                    commit_pc,
   output logic                           flush_valid,
   output logic [31:0]                    flush_pc
);
   localparam int NS = RS_ENTRIES * NUM_FUS;
   localparam int SW = $clog2(NS);
   localparam int RI = $clog2(ROB_ENTRIES);
   localparam int AW = $clog2(NUM_AREGS);
   localparam int PW = $clog2(NUM_PREGS);
   localparam logic [RI:0] ROB_FULL_CNT = (RI+1)'(ROB_ENTRIES);

   typedef enum logic [2:0] {
      OP_ADDI = 3'd0, OP_LUI = 3'd1, OP_AUIPC = 3'd2, OP_JAL = 3'd3, OP_BEQZ = 3'd4
   } op_e;

   logic [NS-1:0] rs_vld_q, rs_vld_d, rs_bt_q, iss_clr;
   logic [NS-1:0] rs_mask_q [NS];
   logic [2:0]    rs_op_q   [NS];
   logic [31:0]   rs_pc_q   [NS];
   logic [31:0]   rs_imm_q  [NS];
   logic [RI-1:0] rs_rob_q  [NS];
   logic [AW-1:0] rs_areg_q [NS];
   logic [PW-1:0] rs_preg_q [NS];

   logic [NUM_FUS-1:0] ex_vld_q, ex_bt_q, ex_misp, ex_wr;
   logic [2:0]    ex_op_q   [NUM_FUS];
   logic [31:0]   ex_pc_q   [NUM_FUS];
   logic [31:0]   ex_imm_q  [NUM_FUS];
   logic [RI-1:0] ex_rob_q  [NUM_FUS];
   logic [AW-1:0] ex_areg_q [NUM_FUS];
   logic [PW-1:0] ex_preg_q [NUM_FUS];
   logic [31:0]   ex_res    [NUM_FUS];
   logic [31:0]   ex_fpc    [NUM_FUS];

   logic [ROB_ENTRIES-1:0] rob_vld_q, rob_done_q, rob_wb_q, rob_misp_q;
   logic [AW-1:0] rob_areg_q [ROB_ENTRIES];
   logic [31:0]   rob_pc_q   [ROB_ENTRIES];
   logic [31:0]   rob_val_q  [ROB_ENTRIES];
   logic [31:0]   rob_fpc_q  [ROB_ENTRIES];
   logic [RI-1:0] head_q, tail_q;
   logic [RI:0]   count_q, count_d;
   logic [31:0]   prf_q [NUM_PREGS];

   logic [NUM_FUS-1:0] free_found, iss_found;
   logic [SW-1:0] free_idx [NUM_FUS];
   logic [SW-1:0] iss_idx  [NUM_FUS];
   logic [SW-1:0] disp_slot;
   logic rob_full, disp_fire, rob_alloc, commit_fire;

   function automatic logic [31:0] exec_result(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm);
      case (op)
         OP_AUIPC: return pc + imm;
         OP_JAL:   return pc + 32'd4;
         OP_BEQZ:  return 32'd0;
         default:  return imm;
      endcase
   endfunction

   function automatic logic exec_taken(input logic [2:0] op, input logic [31:0] imm);
      case (op)
         OP_JAL:  return 1'b1;
         OP_BEQZ: return imm[0];
         default: return 1'b0;
      endcase
   endfunction

   // Lowest-index free slot and lowest-index ready slot per FU
   always_comb begin
      iss_clr = '0;
      for (int f = 0; f < NUM_FUS; f++) begin
         free_found[f] = 1'b0;
         free_idx[f]   = '0;
         iss_found[f]  = 1'b0;
         iss_idx[f]    = '0;
         for (int e = RS_ENTRIES - 1; e >= 0; e--) begin
            if (!rs_vld_q[f*RS_ENTRIES+e]) begin
               free_found[f] = 1'b1;
               free_idx[f]   = SW'(f*RS_ENTRIES+e);
            end
            if (rs_vld_q[f*RS_ENTRIES+e] && rs_mask_q[f*RS_ENTRIES+e] == '0) begin
               iss_found[f] = 1'b1;
               iss_idx[f]   = SW'(f*RS_ENTRIES+e);
            end
         end
         if (iss_found[f]) iss_clr[iss_idx[f]] = 1'b1;
      end
   end

   assign rob_full    = (count_q == ROB_FULL_CNT);
   assign disp_ready  = (disp_alu_en ? free_found[0] : free_found[1]) && !rob_full;
   assign disp_slot   = disp_alu_en ? free_idx[0] : free_idx[1];
   assign disp_fire   = disp_valid && disp_instr_valid && disp_ready && !flush_valid;
   assign rob_alloc   = rob_fire_valid && !rob_full && !flush_valid;
   assign commit_fire = !flush_valid && rob_vld_q[head_q] && rob_done_q[head_q];
   assign count_d     = count_q + (RI+1)'(rob_alloc) - (RI+1)'(commit_fire);

   always_comb begin
      rs_vld_d = rs_vld_q & ~iss_clr;
      if (disp_fire) rs_vld_d[disp_slot] = 1'b1;
   end

   always_comb begin
      for (int f = 0; f < NUM_FUS; f++) begin
         ex_res[f]  = exec_result(ex_op_q[f], ex_pc_q[f], ex_imm_q[f]);
         ex_fpc[f]  = exec_taken(ex_op_q[f], ex_imm_q[f]) ? ex_pc_q[f] + ex_imm_q[f] : ex_pc_q[f] + 32'd4;
         ex_misp[f] = exec_taken(ex_op_q[f], ex_imm_q[f]) != ex_bt_q[f];
         ex_wr[f]   = ex_vld_q[f] && (ex_op_q[f] != OP_BEQZ) && (ex_areg_q[f] != '0) && rob_wb_q[ex_rob_q[f]];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs_vld_q   <= '0;
         for (int s = 0; s < NS; s++) rs_mask_q[s] <= '0;
         ex_vld_q   <= '0;
         rob_vld_q  <= '0;
         rob_done_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         commit_valid <= 1'b0;
         commit_areg  <= '0;
         commit_value <= '0;
         commit_pc    <= '0;
         flush_valid  <= 1'b0;
         flush_pc     <= '0;
         for (int p = 0; p < NUM_PREGS; p++) prf_q[p] <= '0;
      end else if (flush_valid) begin
         rs_vld_q     <= '0;
         ex_vld_q     <= '0;
         rob_vld_q    <= '0;
         rob_done_q   <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         commit_valid <= 1'b0;
         flush_valid  <= 1'b0;
      end else begin
         // Wake-up: issuing slots drop out of every mask, including a same-cycle dispatch
         for (int s = 0; s < NS; s++) rs_mask_q[s] <= rs_mask_q[s] & ~iss_clr;
         if (disp_fire) rs_mask_q[disp_slot] <= dependency_mask & rs_vld_q & ~iss_clr;
         rs_vld_q <= rs_vld_d;
         ex_vld_q <= iss_found;
         for (int f = 0; f < NUM_FUS; f++)
            if (ex_wr[f]) prf_q[ex_preg_q[f]] <= ex_res[f];
         if (rob_alloc) begin
            rob_vld_q[tail_q]  <= 1'b1;
            rob_done_q[tail_q] <= 1'b0;
            tail_q             <= tail_q + 1'b1;
         end
         for (int f = 0; f < NUM_FUS; f++)
            if (ex_vld_q[f]) rob_done_q[ex_rob_q[f]] <= 1'b1;
         commit_valid <= commit_fire;
         flush_valid  <= commit_fire && rob_misp_q[head_q];
         if (commit_fire) begin
            rob_vld_q[head_q] <= 1'b0;
            head_q       <= head_q + 1'b1;
            commit_areg  <= rob_areg_q[head_q];
            commit_value <= rob_val_q[head_q];
            commit_pc    <= rob_pc_q[head_q];
            flush_pc     <= rob_fpc_q[head_q];
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (disp_fire) begin
         rs_op_q[disp_slot]   <= disp_opcode;
         rs_pc_q[disp_slot]   <= disp_pc;
         rs_imm_q[disp_slot]  <= disp_imm;
         rs_rob_q[disp_slot]  <= disp_rob_idx;
         rs_areg_q[disp_slot] <= disp_dst_areg;
         rs_preg_q[disp_slot] <= disp_dst_preg;
         rs_bt_q[disp_slot]   <= disp_br_taken;
      end
      for (int f = 0; f < NUM_FUS; f++) begin
         if (iss_found[f]) begin
            ex_op_q[f]   <= rs_op_q[iss_idx[f]];
            ex_pc_q[f]   <= rs_pc_q[iss_idx[f]];
            ex_imm_q[f]  <= rs_imm_q[iss_idx[f]];
            ex_rob_q[f]  <= rs_rob_q[iss_idx[f]];
            ex_areg_q[f] <= rs_areg_q[iss_idx[f]];
            ex_preg_q[f] <= rs_preg_q[iss_idx[f]];
            ex_bt_q[f]   <= rs_bt_q[iss_idx[f]];
         end
      end
      if (rob_alloc) begin
         rob_areg_q[tail_q] <= rob_dest_reg;
         rob_wb_q[tail_q]   <= rob_wb_en;
         rob_pc_q[tail_q]   <= disp_pc;
      end
      for (int f = 0; f < NUM_FUS; f++) begin
         if (ex_vld_q[f]) begin
            rob_val_q[ex_rob_q[f]]  <= ex_res[f];
            rob_misp_q[ex_rob_q[f]] <= ex_misp[f];
            rob_fpc_q[ex_rob_q[f]]  <= ex_fpc[f];
         end
      end
   end

`ifdef COMMIT_TRACE_EN
   logic [31:0] cyc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cyc_q <= '0;
      else      cyc_q <= cyc_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (commit_valid)
         $display("COMMIT pc=%h areg=%0d val=%0d cycle=%0d", commit_pc, commit_areg, commit_value, cyc_q);
   end
`endif

endmodule

// File: tb/tb_core_top.sv
// Scoreboard bench for core_top: stimulus pushes expected commits, a negedge monitor pops and compares.
module tb_core_top;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        disp_valid = 1'b0;
   logic [7:0]  dependency_mask = '0;
   logic [2:0]  disp_opcode = '0;
   logic [31:0] disp_pc = '0;
   logic [2:0]  disp_rob_idx = '0;
   logic [4:0]  disp_dst_areg = '0;
   logic [5:0]  disp_dst_preg = '0;
   logic [31:0] disp_imm = '0;
   logic        disp_instr_valid = 1'b0;
   logic        disp_alu_en = 1'b0;
   logic        disp_br_taken = 1'b0;
   logic        rob_fire_valid = 1'b0;
   logic [4:0]  rob_dest_reg = '0;
   logic        rob_wb_en = 1'b0;
   logic        disp_ready, commit_valid, flush_valid;
   logic [4:0]  commit_areg;
   logic [31:0] commit_value, commit_pc, flush_pc;

   core_top dut (
      .clk(clk), .rst(rst), .disp_valid(disp_valid), .dependency_mask(dependency_mask),
      .disp_opcode(disp_opcode), .disp_pc(disp_pc), .disp_rob_idx(disp_rob_idx),
      .disp_dst_areg(disp_dst_areg), .disp_dst_preg(disp_dst_preg), .disp_imm(disp_imm),
      .disp_instr_valid(disp_instr_valid), .disp_alu_en(disp_alu_en), .disp_br_taken(disp_br_taken),
      .rob_fire_valid(rob_fire_valid), .rob_dest_reg(rob_dest_reg), .rob_wb_en(rob_wb_en),
      .disp_ready(disp_ready), .commit_valid(commit_valid), .commit_areg(commit_areg),
      .commit_value(commit_value), .commit_pc(commit_pc), .flush_valid(flush_valid), .flush_pc(flush_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  areg;
      logic [31:0] val;
      logic [31:0] pc;
      logic        fl;
      logic [31:0] fpc;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       me;
   int         total = 0;
   int         bad = 0;
   logic [2:0] tail_m = '0;
   logic       took;

   // Architectural meaning of each opcode, straight from the instruction definitions
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                                  input logic bt, input logic [4:0] areg);
      exp_t e;
      logic taken;
      e.areg = areg;
      e.pc   = pc;
      taken  = 1'b0;
      if (op == 3'd3) begin
         e.val = pc + 32'd4;
         taken = 1'b1;
      end else if (op == 3'd4) begin
         e.val = 32'd0;
         taken = imm[0];
      end else if (op == 3'd2) begin
         e.val = pc + imm;
      end else begin
         e.val = imm;
      end
      e.fl  = (taken != bt);
      e.fpc = taken ? pc + imm : pc + 32'd4;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, expv);
      end
   endtask

   task automatic dispatch(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [4:0] areg, input logic [5:0] preg, input logic alu,
                           input logic bt, input logic [7:0] mask, input logic iv, input logic push,
                           output logic ok);
      @(negedge clk);
      disp_valid       = 1'b1;
      disp_instr_valid = iv;
      disp_opcode      = op;
      disp_pc          = pc;
      disp_imm         = imm;
      disp_dst_areg    = areg;
      disp_dst_preg    = preg;
      disp_alu_en      = alu;
      disp_br_taken    = bt;
      dependency_mask  = mask;
      disp_rob_idx     = tail_m;
      rob_fire_valid   = 1'b1;
      rob_dest_reg     = areg;
      rob_wb_en        = 1'b1;
      #1;
      ok = disp_ready;
      if (!ok) rob_fire_valid = 1'b0;
      else begin
         tail_m = tail_m + 3'd1;
         if (push && iv) exp_q.push_back(model(op, pc, imm, bt, areg));
      end
      @(posedge clk);
      #1;
      disp_valid       = 1'b0;
      disp_instr_valid = 1'b0;
      rob_fire_valid   = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (commit_valid) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_commit got pc=%h areg=%0d val=%h flush=%b want=no commit",
                        commit_pc, commit_areg, commit_value, flush_valid);
            end else begin
               me = exp_q.pop_front();
               if (commit_areg !== me.areg || commit_value !== me.val || commit_pc !== me.pc ||
                   flush_valid !== me.fl || (me.fl && flush_pc !== me.fpc)) begin
                  bad++;
                  $display("FAIL commit got pc=%h areg=%0d val=%h fl=%b fpc=%h want pc=%h areg=%0d val=%h fl=%b fpc=%h",
                           commit_pc, commit_areg, commit_value, flush_valid, flush_pc,
                           me.pc, me.areg, me.val, me.fl, me.fpc);
               end
            end
         end else if (flush_valid) begin
            total++;
            bad++;
            $display("FAIL flush_without_commit got flush_valid=1 want=0");
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] imm;
      logic        bt;

      // Reset held two cycles
      repeat (2) @(posedge clk);
      #1;
      check("rst_commit_valid", 32'(commit_valid), 32'd0);
      check("rst_flush_valid", 32'(flush_valid), 32'd0);
      check("rst_commit_areg", 32'(commit_areg), 32'd0);
      check("rst_commit_value", commit_value, 32'd0);
      check("rst_commit_pc", commit_pc, 32'd0);
      check("rst_flush_pc", flush_pc, 32'd0);
      check("rst_disp_ready", 32'(disp_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      // Single ADDI: commit pulse three edges after the dispatch edge
      dispatch(3'd0, 32'h0, 32'd16, 5'd1, 6'd33, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, took);
      check("addi_accept", 32'(took), 32'd1);
      check("addi_lat_e0", 32'(commit_valid), 32'd0);
      @(posedge clk); #1;
      check("addi_lat_e1", 32'(commit_valid), 32'd0);
      @(posedge clk); #1;
      check("addi_lat_e2", 32'(commit_valid), 32'd0);
      @(posedge clk); #1;
      check("addi_lat_e3", 32'(commit_valid), 32'd1);
      check("addi_prf33", dut.prf_q[33], 32'd16);
      wait_drain(20);

      // Producer/consumer pair across FUs
      dispatch(3'd2, 32'h100, 32'd4, 5'd2, 6'd34, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, took);
      dispatch(3'd1, 32'h104, 32'h12345000, 5'd3, 6'd35, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, took);
      wait_drain(30);

      // Random correctly-predicted traffic
      for (int i = 0; i < 60; i++) begin
         op  = 3'($urandom_range(0, 4));
         imm = $urandom;
         bt  = (op == 3'd3) ? 1'b1 : (op == 3'd4) ? imm[0] : 1'b0;
         dispatch(op, $urandom & 32'hFFFF_FFFC, imm, 5'($urandom), 6'($urandom),
                  1'($urandom), bt, 8'($urandom), 1'b1, 1'b1, took);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      wait_drain(300);

      // Mispredicted BEQZ: younger work (including a flush-cycle dispatch) must vanish
      dispatch(3'd4, 32'h20, 32'd9, 5'd0, 6'd40, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, took);
      for (int i = 0; i < 4; i++)
         dispatch(3'd0, 32'h24 + 32'(4*i), 32'd5, 5'd7, 6'd41, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, took);
      repeat (10) @(negedge clk);
      tail_m = '0;
      check("flush_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      dispatch(3'd1, 32'h40, 32'hABCD0000, 5'd8, 6'd42, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, took);
      wait_drain(20);

      // Fill the ROB behind a never-completing head entry
      dispatch(3'd0, 32'h200, 32'd1, 5'd5, 6'd43, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, took);
      for (int i = 0; i < 7; i++)
         dispatch(3'd0, 32'h204 + 32'(4*i), 32'(i), 5'd9, 6'd44, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, took);
      check("rob_full_ready", 32'(disp_ready), 32'd0);
      dispatch(3'd0, 32'h300, 32'd2, 5'd10, 6'd45, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, took);
      check("ninth_dropped", 32'(took), 32'd0);
      repeat (5) @(negedge clk);

      // Asynchronous reset mid-operation
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("async_rst_ready", 32'(disp_ready), 32'd1);
      check("async_rst_commit", 32'(commit_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tail_m = '0;
      repeat (10) @(negedge clk);

      // Reset while a commit pulse is on the outputs
      dispatch(3'd0, 32'h300, 32'd77, 5'd6, 6'd46, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, took);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_commit", 32'(commit_valid), 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_commit", 32'(commit_valid), 32'd0);
      check("mid_rst_value", commit_value, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tail_m = '0;
      repeat (10) @(negedge clk);

      check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/core_top.md
Name: core_top

Overview:
- Minimal out-of-order back end: dispatch port, unified scheduler, single-cycle ALU/branch execution, physical register file (PRF) and in-order reorder buffer (ROB).
- Front end (fetch/decode/rename) lives upstream and presents one dispatch packet per cycle.
- Instructions issue when their scheduler dependencies clear, write the PRF, and retire in program order through the commit port.

Parameters:
- RS_ENTRIES, 4, scheduler slots per functional unit.
- NUM_FUS, 2, functional units: FU0 = ALU, FU1 = branch.
- ROB_ENTRIES, 8, ROB depth (power of 2).
- NUM_AREGS, 32, architectural registers.
- NUM_PREGS, 64, physical registers.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- disp_valid  in  1  scheduler dispatch request.
- dependency_mask  in  RS_ENTRIES*NUM_FUS  bit i = waits on global scheduler slot i (i = fu*RS_ENTRIES + entry).
- disp_opcode  in  3  ADDI=0, LUI=1, AUIPC=2, JAL=3, BEQZ=4.
- disp_pc  in  32  instruction PC.
- disp_rob_idx  in  log2(ROB_ENTRIES)  ROB slot of the instruction.
- disp_dst_areg  in  log2(NUM_AREGS)  destination architectural register.
- disp_dst_preg  in  log2(NUM_PREGS)  destination physical register.
- disp_imm  in  32  immediate.
- disp_instr_valid  in  1  0 = bubble, allocate nothing.
- disp_alu_en  in  1  1 = route to FU0, 0 = route to FU1.
- disp_br_taken  in  1  front-end prediction.
- rob_fire_valid  in  1  allocate ROB slot at tail.
- rob_dest_reg  in  log2(NUM_AREGS)  areg recorded in the ROB.
- rob_wb_en  in  1  instruction writes a register.
- disp_ready  out  1  a free slot exists in the target FU and the ROB is not full.
- commit_valid  out  1  one instruction retires this cycle.
- commit_areg  out  log2(NUM_AREGS)  retired destination areg.
- commit_value  out  32  retired result.
- commit_pc  out  32  retired PC.
- flush_valid  out  1  branch misprediction detected at commit.
- flush_pc  out  32  correct redirect target.

Behaviour:
- Reset (async, rst=0):
  - all scheduler slots and ROB entries invalid; head = tail = 0.
  - PRF cleared to 0.
  - all outputs 0, except disp_ready = 1.
- Dispatch, sampled at posedge:
  - When disp_valid & disp_instr_valid & disp_ready, the packet goes to the lowest-index free slot of the selected FU.
  - The slot stores the mask ANDed with the currently-valid slot bits.
  - Dispatch with disp_ready=0 is dropped.
- ROB allocation:
  - rob_fire_valid writes entry[tail] = {dest_reg, wb_en, pc, done=0}, then tail++ (mod ROB_ENTRIES).
  - disp_rob_idx must equal tail; on mismatch, disp_rob_idx wins for scheduler tracking.
- Issue:
  - Per FU, the oldest-index valid slot whose mask is zero issues, one cycle after dispatch at the earliest.
  - The slot frees on issue.
  - Its global bit is cleared in every other slot's mask in the same cycle.
  - Wake-up becomes visible for issue the following cycle.
- Execute, one cycle:
  - ADDI: imm (src x0).
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL: result pc+4, target pc+imm, actual taken = 1.
  - BEQZ: result 0, target pc+imm, actual taken = imm[0] (test hook); no register write.
  - All arithmetic 32-bit wrapping.
- Writeback:
  - At the end of the execute cycle, PRF[dst_preg] <= result (when wb_en and areg≠0).
  - ROB[rob_idx] gets done=1, value, mispredict = (actual ≠ br_taken), target.
  - Both FUs may write back the same cycle; writes to distinct ROB slots both land.
- Commit:
  - When ROB[head] is valid & done: commit_valid=1 for one cycle with areg/value/pc; head++.
  - Registered outputs; at most one commit per cycle.
- Latency: dispatch at edge N, issue N+1, writeback N+2, commit pulse during cycle after edge N+3.
- Misprediction:
  - At commit, flush_valid=1 and flush_pc = actual taken ? target : pc+4.
  - All scheduler slots and ROB entries are invalidated next edge; head = tail = 0.
  - Dispatch in the flush cycle is ignored.
- Full/empty:
  - ROB full when count == ROB_ENTRIES → disp_ready=0.
  - Simultaneous commit and allocate at full: the allocation is still rejected.
- Reset mid-operation aborts everything immediately; no commit is produced.

Optional Feature:
- COMMIT_TRACE_EN defined: each commit prints a simulation $display line "COMMIT pc=<hex> areg=<dec> val=<dec> cycle=<n>" using an internal cycle counter.
- Undefined: no print and no counter logic; identical port behaviour.

Test Plan:
- Reset: hold rst=0 two cycles → all outputs 0, disp_ready=1, no commit for 10 cycles after release.
- ADDI, no deps (mask 0, pc 0, rob 0, areg 1, preg 33, imm 16, alu_en 1, br_taken 0) → commit_valid exactly 3 cycles after dispatch edge, commit_areg=1, commit_value=16, commit_pc=0, PRF[33]=16.
- Dependency: AUIPC pc 0x100 imm 4 in slot 0, then LUI with mask bit0 set → LUI issues only after slot 0 issues; commits in order, values 0x104 then imm.
- Misprediction: BEQZ imm 9 (taken), br_taken 0, pc 0x20 → flush_valid pulse, flush_pc=0x29; younger entries never commit.
- Fill ROB with 8 dispatches without commits (deps blocked) → disp_ready=0; 9th dropped.
- Async reset asserted mid-execution → outputs clear immediately, no stale commit after release.
